// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal word FIFO: start bit, LSB-first data,
// optional parity and 1..2 stop bits, one bit every CLKS_PER_BIT clocks.
module uart_tx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_BITS-1:0]        in_data,
   output logic                        TX,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [2:0]                  dbg_state
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [BW-1:0]          baud_q, baud_d;
   logic [3:0]             bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   tx_q, tx_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_BITS-1:0]   head;
   logic                   push, pop, bit_end, fifo_empty;

   // Handshake: a word transfers on a rising edge where in_valid && in_ready;
   // in_ready depends only on the registered count, never on this cycle's pop.
   assign in_ready   = (count_q != FULL);
   assign push       = in_valid && in_ready;
   assign fifo_empty = (count_q == '0);
   assign head       = mem_q[rd_ptr_q];
   assign bit_end    = (baud_q == BAUD_LAST);

   assign TX         = tx_q;
   assign busy       = (state_q != S_IDLE);
   assign fifo_count = count_q;
   assign dbg_state  = state_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_START;
               baud_d  = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // Chain straight into the next start bit so frames stay contiguous.
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         shift_d = head;
         par_d   = (PARITY == 2) ? ^head : ~^head;
      end

      // TX is registered from the next state so the line changes on the same
      // edge that enters each bit.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) mem_q[wr_ptr_q] <= in_data;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame configurations checked against a
// frame-level reference model, plus directed vectors and corner sequences.
module tb_uart_tx_fifo;
   logic       CLK = 1'b0;
   logic       RST_N;
   logic [3:0] in_valid;
   logic [3:0] in_ready;
   logic [3:0] tx;
   logic [3:0] busy;
   logic [8:0] in_data [4];
   logic [2:0] fcnt [4];
   logic [2:0] dbg [4];

   always #5 CLK = ~CLK;

   // Per-instance frame configuration (must match the instantiations below).
   int db  [4] = '{8, 8, 8, 7};
   int par [4] = '{0, 2, 1, 0};
   int sb  [4] = '{1, 1, 1, 2};
   int cpb [4] = '{1, 4, 4, 1};

   uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0][7:0]), .TX(tx[0]), .busy(busy[0]), .fifo_count(fcnt[0]), .dbg_state(dbg[0]));
   uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1][7:0]), .TX(tx[1]), .busy(busy[1]), .fifo_count(fcnt[1]), .dbg_state(dbg[1]));
   uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2][7:0]), .TX(tx[2]), .busy(busy[2]), .fifo_count(fcnt[2]), .dbg_state(dbg[2]));
   uart_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_data(in_data[3][6:0]), .TX(tx[3]), .busy(busy[3]), .fifo_count(fcnt[3]), .dbg_state(dbg[3]));

   // Reference model: a word list per instance and the bit image of the frame
   // currently on the line, with the number of line cycles it still occupies.
   logic [8:0]  mq [4][4];
   int          mcnt [4];
   int          rem [4];
   int          flen [4];
   logic [15:0] fb [4];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, inst, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int i);
      mcnt[i] = 0;
      rem[i]  = 0;
      flen[i] = 0;
      fb[i]   = '0;
   endtask

   task automatic build_frame(input int i, input logic [8:0] w);
      int k;
      int ones;
      fb[i] = '0;
      k = 1;
      ones = 0;
      for (int j = 0; j < db[i]; j++) begin
         fb[i][k] = w[j];
         ones += int'(w[j]);
         k++;
      end
      if (par[i] != 0) begin
         fb[i][k] = (par[i] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
         k++;
      end
      for (int s = 0; s < sb[i]; s++) begin
         fb[i][k] = 1'b1;
         k++;
      end
      flen[i] = k * cpb[i];
   endtask

   task automatic model_edge(input int i);
      logic [8:0] w;
      logic       rdy;
      logic       pu;
      logic       po;
      rdy = (mcnt[i] != 4);
      pu  = in_valid[i] && rdy;
      po  = (rem[i] <= 1) && (mcnt[i] > 0);
      if (po) begin
         build_frame(i, mq[i][0]);
         for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j+1];
         mcnt[i]--;
         rem[i] = flen[i];
      end else if (rem[i] > 0) begin
         rem[i]--;
      end
      if (pu) begin
         w = in_data[i] & 9'((1 << db[i]) - 1);
         mq[i][mcnt[i]] = w;
         mcnt[i]++;
      end
   endtask

   task automatic check_outputs(input int i);
      logic exp_tx;
      exp_tx = (rem[i] == 0) ? 1'b1 : fb[i][(flen[i] - rem[i]) / cpb[i]];
      check("tx", i, tx[i], exp_tx);
      check("busy", i, busy[i], (rem[i] != 0));
      check("in_ready", i, in_ready[i], (mcnt[i] != 4));
      check("fifo_count", i, fcnt[i], mcnt[i]);
   endtask

   task automatic tick();
      @(posedge CLK);
      for (int i = 0; i < 4; i++) model_edge(i);
      @(negedge CLK);
      for (int i = 0; i < 4; i++) check_outputs(i);
   endtask

   typedef struct {
      int          inst;
      logic [8:0]  data;
      int          nbits;
      logic [15:0] bits;
   } vec_t;

   initial begin
      #3000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec [4];
      int   idx;
      int   guard;
      int   busy_cycles;
      logic saw_full;
      logic rdy;

      // Frame images, bit k = k-th bit on the line.
      vec[0] = '{inst: 0, data: 9'h0A5, nbits: 10, bits: 16'h034A};
      vec[1] = '{inst: 1, data: 9'h007, nbits: 11, bits: 16'h060E};
      vec[2] = '{inst: 2, data: 9'h007, nbits: 11, bits: 16'h040E};
      vec[3] = '{inst: 3, data: 9'h055, nbits: 10, bits: 16'h03AA};

      RST_N    = 1'b0;
      in_valid = '0;
      for (int i = 0; i < 4; i++) begin
         in_data[i] = '0;
         model_reset(i);
      end
      repeat (2) @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         check("reset_tx", i, tx[i], 1);
         check("reset_busy", i, busy[i], 0);
         check("reset_in_ready", i, in_ready[i], 1);
         check("reset_count", i, fcnt[i], 0);
      end
      RST_N = 1'b1;
      tick();

      // Directed single frames; in_data is scrambled right after the push.
      for (int r = 0; r < 4; r++) begin
         int i;
         i = vec[r].inst;
         in_valid[i] = 1'b1;
         in_data[i]  = vec[r].data;
         tick();
         in_valid[i] = 1'b0;
         in_data[i]  = 9'($urandom);
         for (int c = 0; c < vec[r].nbits * cpb[i]; c++) begin
            tick();
            check("vec_tx", i, tx[i], vec[r].bits[c / cpb[i]]);
            check("vec_busy", i, busy[i], 1);
         end
         tick();
         check("vec_end_tx", i, tx[i], 1);
         check("vec_end_busy", i, busy[i], 0);
      end

      // Burst of six words into a four-deep FIFO with in_valid held high.
      idx = 0;
      guard = 0;
      busy_cycles = 0;
      saw_full = 1'b0;
      while (idx < 6 && guard < 200) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 9'(idx + 1);
         rdy = in_ready[0];
         tick();
         guard++;
         if (rdy) idx++;
         if (fcnt[0] == 3'd4 && in_ready[0] == 1'b0) saw_full = 1'b1;
         busy_cycles += int'(busy[0]);
      end
      in_valid[0] = 1'b0;
      check("burst_accepted", 0, idx, 6);
      check("burst_full_seen", 0, saw_full, 1);
      guard = 0;
      while (busy[0] && guard < 200) begin
         tick();
         busy_cycles += int'(busy[0]);
         guard++;
      end
      check("burst_drained", 0, busy[0], 0);
      check("burst_busy_cycles", 0, busy_cycles, 60);

      // Reset in the middle of a data bit with three words queued.
      for (int k = 0; k < 4; k++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 9'($urandom);
         tick();
      end
      in_valid[0] = 1'b0;
      check("pre_reset_count", 0, fcnt[0], 3);
      check("pre_reset_busy", 0, busy[0], 1);
      RST_N = 1'b0;
      #1;
      check("abort_tx", 0, tx[0], 1);
      check("abort_busy", 0, busy[0], 0);
      check("abort_count", 0, fcnt[0], 0);
      check("abort_in_ready", 0, in_ready[0], 1);
      for (int i = 0; i < 4; i++) model_reset(i);
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      busy_cycles = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         busy_cycles += int'(busy[0]);
      end
      check("post_reset_quiet", 0, busy_cycles, 0);

      // Push and pop on the same edge with two words held.
      for (int k = 0; k < 3; k++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 9'($urandom);
         tick();
      end
      in_valid[0] = 1'b0;
      check("pp_setup_count", 0, fcnt[0], 2);
      guard = 0;
      while (rem[0] != 1 && guard < 100) begin
         tick();
         guard++;
      end
      check("pp_frame_end_reached", 0, (guard < 100), 1);
      in_valid[0] = 1'b1;
      in_data[0]  = 9'($urandom);
      tick();
      in_valid[0] = 1'b0;
      check("pp_count_held", 0, fcnt[0], 2);

      // Random traffic on all instances; the model checks every cycle.
      for (int c = 0; c < 900; c++) begin
         for (int i = 0; i < 4; i++) begin
            in_valid[i] = (c < 450) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            in_data[i]  = 9'($urandom);
         end
         tick();
      end
      in_valid = '0;
      guard = 0;
      while ((busy != 4'b0000 || mcnt[0] + mcnt[1] + mcnt[2] + mcnt[3] != 0) && guard < 600) begin
         tick();
         guard++;
      end
      for (int i = 0; i < 4; i++) begin
         check("final_busy", i, busy[i], 0);
         check("final_count", i, fcnt[i], 0);
         check("final_tx", i, tx[i], 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal word FIFO and a valid/ready input handshake. It replaces single-shot edge-triggered senders. Words are serialised LSB-first with a configurable frame: start bit, DATA_BITS data bits, optional parity, and 1 or 2 stop bits. An integer clock divider generates the bit period. It sits between any on-chip producer and the TX pin.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame (1 or 2)
CLKS_PER_BIT, 1, CLK cycles per bit (>=1); 1 gives baud = f(CLK)
FIFO_DEPTH, 4, FIFO entries; power of 2, >=2

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  reset, asynchronous, active-low
in_valid  input  1  producer has a word on in_data
in_ready  output  1  FIFO can accept a word (not full)
in_data  input  DATA_BITS  word to transmit
TX  output  1  serial line, idle high
busy  output  1  a frame is in progress (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  words held in FIFO

Interface clocking and reset:
- One clock; reset is asynchronous and active-low.
- All state resets asynchronously on RST_N low.

Behaviour:
- Reset values: TX=1, busy=0, in_ready=1, fifo_count=0, state=IDLE, FIFO empty, baud and bit counters 0.
- Reset mid-frame aborts the frame immediately: TX returns to 1 and FIFO contents are discarded.
- Push:
  - A word is written when in_valid & in_ready at a rising edge.
  - in_ready = (fifo_count != FIFO_DEPTH), driven from registered count only; no combinational path from pop.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
- Pop: occurs in the cycle the FSM leaves IDLE, or leaves the final STOP bit with the FIFO non-empty. The word is latched into a shift register.
- Simultaneous push and pop: fifo_count is unchanged and both operations take effect.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: TX=1. If FIFO non-empty, pop and go to START at the next edge.
  - START: TX=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: TX=shift[0], shift right each bit. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: TX=^word for even, ~^word for odd. One bit, then STOP.
  - STOP: TX=1 for STOP_BITS bits. At the end: if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Latency: with the FIFO empty and IDLE, an accepted push at edge N shows in fifo_count after N. The FSM pops at edge N+1 and TX falls at N+1.
- Bit timing:
  - A baud counter counts 0..CLKS_PER_BIT-1; the bit advances when it reaches CLKS_PER_BIT-1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- TX is driven from a register (glitch-free).
- busy=1 from the START entry edge until the IDLE entry edge.
- Back-to-back frames are contiguous: the last stop-bit period is immediately followed by the next start bit.
- in_data is sampled only at push. Changes while in_valid=0 or in_ready=0 have no effect.

Test Plan:
1. Defaults, CLKS_PER_BIT=1: push 8'hA5 once -> TX = 0,1,0,1,0,0,1,0,1,1 on consecutive cycles starting the cycle after the pop; busy high for 10 cycles; then TX=1, busy=0.
2. PARITY=2, CLKS_PER_BIT=4, push 8'h07 -> start, 1,1,1,0,0,0,0,0, parity=1, stop; each bit held 4 cycles; frame 44 cycles. Repeat with PARITY=1 -> parity bit 0.
3. Burst: push 6 words 8'h01..8'h06 with in_valid held high, FIFO_DEPTH=4 -> in_ready drops when fifo_count=4. Every word is eventually accepted in order. Six frames are transmitted back-to-back with no idle cycle between stop and next start.
4. STOP_BITS=2, DATA_BITS=7, push 7'h55 -> frame 10 bits. Both stop bits high. TX bit stream checked by a reference UART receiver model.
5. Assert RST_N low for 1 cycle in the middle of DATA with 3 words queued -> TX=1, busy=0, fifo_count=0 immediately. No frame is emitted after release until a new push.
6. Simultaneous push and pop at fifo_count=2 -> count stays 2. Data order preserved across pointer wrap after 10 mixed pushes and pops.
